// File: rtl/z80_sys_pkg.sv
// Shared constants and types for the Z80 system glue: mapper control bits,
// default I/O ports and the wait-state FSM encoding.
package z80_sys_pkg;

   localparam int CTRL_MAP_EN  = 0;
   localparam int CTRL_ROM_OFF = 1;

   localparam logic [7:0] MAPPER_IO_BASE = 8'h78;
   localparam logic [7:0] ROM_OFF_PORT   = 8'h38;

   typedef enum logic [1:0] {
      WS_IDLE,
      WS_WAIT,
      WS_HOLD
   } waitState_t;

   // Physical SRAM address width: page offset bits plus bank number bits.
   function automatic int memAddrWidth(input int pageBits, input int bankBits);
      return 16 - pageBits + bankBits;
   endfunction

endpackage

// File: rtl/z80_wait_gen.sv
// Memory wait-state generator: holds wait_n low for WAIT_CLKS clocks after a
// memory strobe falls, releasing early if the strobe is withdrawn.
module z80_wait_gen #(
   parameter int WAIT_CLKS = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic n_memrd,
   input  logic n_memwr,
   output logic wait_n
);
   import z80_sys_pkg::*;

   logic memIdle;
   assign memIdle = n_memrd & n_memwr;

   generate
      if (WAIT_CLKS == 0) begin : g_noWait
         assign wait_n = 1'b1;
      end else begin : g_wait
         waitState_t state, stateNxt;
         logic [3:0] cnt, cntNxt;
         logic       memIdleQ;

         // memIdleQ follows the bus even in reset so a strobe that is already
         // low when reset drops is not mistaken for a fresh access.
         always_ff @(posedge clk) begin
            if (reset) begin
               state    <= WS_IDLE;
               cnt      <= 4'd0;
               memIdleQ <= memIdle;
            end else begin
               state    <= stateNxt;
               cnt      <= cntNxt;
               memIdleQ <= memIdle;
            end
         end

         // wait_n is driven from the live strobe so an aborted access frees
         // the CPU in the same cycle.
         always_comb begin
            stateNxt = state;
            cntNxt   = cnt;
            wait_n   = 1'b1;
            case (state)
               WS_IDLE: begin
                  if (memIdleQ && !memIdle) begin
                     stateNxt = WS_WAIT;
                     cntNxt   = 4'(WAIT_CLKS);
                  end
               end
               WS_WAIT: begin
                  if (memIdle) begin
                     stateNxt = WS_IDLE;
                  end else begin
                     wait_n = 1'b0;
                     if (cnt == 4'd1) stateNxt = WS_HOLD;
                     else             cntNxt   = cnt - 4'd1;
                  end
               end
               WS_HOLD: begin
                  if (memIdle) stateNxt = WS_IDLE;
               end
               default: stateNxt = WS_IDLE;
            endcase
         end
      end
   endgenerate

endmodule

// File: rtl/z80_bank_mapper.sv
// Z80 memory mapper: per-page bank registers, boot-ROM overlay and chip
// selects, with memory wait states from z80_wait_gen.
module z80_bank_mapper #(
   parameter int         PAGE_BITS    = 2,
   parameter int         BANK_BITS    = 4,
   parameter logic [7:0] IO_BASE      = z80_sys_pkg::MAPPER_IO_BASE,
   parameter logic [7:0] ROM_OFF_PORT = z80_sys_pkg::ROM_OFF_PORT,
   parameter int         ROM_AW       = 13,
   parameter int         WAIT_CLKS    = 1,
   localparam int        AW           = z80_sys_pkg::memAddrWidth(PAGE_BITS, BANK_BITS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [15:0]   cpu_addr,
   input  logic [7:0]    cpu_dout,
   input  logic          n_iowr,
   input  logic          n_iord,
   input  logic          n_memrd,
   input  logic          n_memwr,
   output logic [AW-1:0] mem_addr,
   output logic          rom_cs_n,
   output logic          ram_cs_n,
   output logic          mapper_cs_n,
   output logic [7:0]    mapper_dout,
   output logic          wait_n
);
   import z80_sys_pkg::*;

   localparam int NPAGE = 1 << PAGE_BITS;
   localparam int OFFW  = 16 - PAGE_BITS;

   logic [BANK_BITS-1:0] bank [NPAGE];
   logic                 mapEn, romOff;
   logic [7:0]           wrAddr, wrData;
   logic                 iowrQ;
   logic [PAGE_BITS-1:0] page;

   // The block is aligned, so the port offset is simply the low address bits.
   function automatic logic inBlock(input logic [7:0] port);
      return port[7:PAGE_BITS+1] == IO_BASE[7:PAGE_BITS+1];
   endfunction

   // Address and data are captured through the strobe and committed on its
   // rising edge, giving exactly one update per OUT.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NPAGE; i++) bank[i] <= BANK_BITS'(i);
         mapEn  <= 1'b0;
         romOff <= 1'b0;
         iowrQ  <= 1'b1;
         wrAddr <= 8'h00;
         wrData <= 8'h00;
      end else begin
         iowrQ <= n_iowr;
         if (!n_iowr) begin
            wrAddr <= cpu_addr[7:0];
            wrData <= cpu_dout;
         end
         if (!iowrQ && n_iowr) begin
            if (wrAddr == ROM_OFF_PORT) begin
               romOff <= 1'b1;
            end else if (inBlock(wrAddr)) begin
               if (!wrAddr[PAGE_BITS]) begin
                  bank[wrAddr[PAGE_BITS-1:0]] <= wrData[BANK_BITS-1:0];
               end else if (wrAddr[PAGE_BITS-1:0] == '0) begin
                  mapEn <= wrData[CTRL_MAP_EN];
                  if (wrData[CTRL_ROM_OFF]) romOff <= 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      mapper_dout = 8'hFF;
      if (inBlock(cpu_addr[7:0])) begin
         if (!cpu_addr[PAGE_BITS])
            mapper_dout = 8'(bank[cpu_addr[PAGE_BITS-1:0]]);
         else if (cpu_addr[PAGE_BITS-1:0] == '0)
            mapper_dout = {6'b0, romOff, mapEn};
      end
   end

   assign mapper_cs_n = !(inBlock(cpu_addr[7:0]) && (!n_iord || !n_iowr));

   assign page     = cpu_addr[15:OFFW];
   assign mem_addr = mapEn ? {bank[page], cpu_addr[OFFW-1:0]} : AW'(cpu_addr);

   assign rom_cs_n = !(!romOff && (cpu_addr[15:ROM_AW] == '0));
   assign ram_cs_n = !rom_cs_n;

   z80_wait_gen #(
      .WAIT_CLKS(WAIT_CLKS)
   ) uWaitGen (
      .clk    (clk),
      .reset  (reset),
      .n_memrd(n_memrd),
      .n_memwr(n_memwr),
      .wait_n (wait_n)
   );

endmodule
